sram_rd_arbiter: RTL

SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

---
 rtl/sram_rd_arbiter_pkg.sv | 16 +
 rtl/sram_rd_arbiter_if.sv | 31 +++
 rtl/sram_rd_arbiter_rr_arbiter.sv | 32 +++
 rtl/sram_rd_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/sram_rd_arbiter_pkg.sv
// Shared widths and FSM encoding for the SRAM R0 read arbiter.
package genie_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Index width for n clients; at least one bit so a single client still works.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rd_arbiter_if.sv
// Client request/response bus plus the SRAM R0 read port seen by the arbiter.
interface sram_rd_arbiter_if #(
  parameter int unsigned NCLI   = 3,
  parameter int unsigned ADDR_W = genie_pkg::ADDR_W,
  parameter int unsigned DATA_W = genie_pkg::DATA_W,
  parameter int unsigned LEN_W  = genie_pkg::LEN_W
);

  logic [NCLI-1:0]        req_valid;
  logic [NCLI-1:0]        req_ready;
  logic [NCLI*ADDR_W-1:0] req_addr;
  logic [NCLI*LEN_W-1:0]  req_len;
  logic [NCLI-1:0]        rsp_valid;
  logic                   rsp_last;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rvalid;
  logic                   rready;
  logic [ADDR_W-1:0]      raddr;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req_valid, req_addr, req_len, rready, rdata,
    input  req_ready, rsp_valid, rsp_last, rsp_data, rvalid, raddr
  );

  modport slave (
    input  req_valid, req_addr, req_len, rready, rdata,
    output req_ready, rsp_valid, rsp_last, rsp_data, rvalid, raddr
  );

endinterface

// File: rtl/sram_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arbiter
  import genie_pkg::*;
#(
  parameter int unsigned NCLI  = 3,
  parameter int unsigned IDX_W = idx_w(NCLI)
) (
  input  logic [NCLI-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NCLI-1:0]  grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [31:0] cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NCLI; i++) begin
      cand = (32'(last_grant) + i) % NCLI;
      if (!any && req[IDX_W'(cand)]) begin
        any                = 1'b1;
        grant[IDX_W'(cand)] = 1'b1;
        winner             = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sram_rd_arbiter.sv
// Arbitrates client burst reads onto the single SRAM R0 port, one burst at a time.
module sram_rd_arbiter
  import genie_pkg::*;
#(
  parameter int unsigned NCLI   = 3,
  parameter int unsigned ADDR_W = genie_pkg::ADDR_W,
  parameter int unsigned DATA_W = genie_pkg::DATA_W,
  parameter int unsigned LEN_W  = genie_pkg::LEN_W
) (
  input logic              clk,
  input logic              rst,
  sram_rd_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NCLI);

  logic [0:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_q;
  logic [NCLI-1:0]   grant_q;
  logic [IDX_W-1:0]  last_grant;
  logic [NCLI-1:0]   rsp_valid_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [NCLI-1:0]   pick;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  rr_arbiter #(
    .NCLI  (NCLI),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .winner     (winner),
    .any        (any_req)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Ready is combinational off the picker, so it must be masked while reset is held.
  assign bus.req_ready = (state == ST_IDLE && !rst) ? pick : '0;
  assign bus.rvalid    = (state == ST_BURST);
  assign bus.raddr     = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      beat_q      <= '0;
      grant_q     <= '0;
      last_grant  <= IDX_W'(NCLI - 1);
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      if (state == ST_IDLE) begin
        if (any_req) begin
          addr_q     <= sel_addr;
          beat_q     <= sel_len;
          grant_q    <= pick;
          last_grant <= winner;
          state      <= ST_BURST;
        end
      end else if (bus.rready) begin
        rsp_data_q  <= bus.rdata;
        rsp_valid_q <= grant_q;
        rsp_last_q  <= (beat_q == '0);
        addr_q      <= addr_q + ADDR_W'(1);
        beat_q      <= beat_q - LEN_W'(1);
        if (beat_q == '0) state <= ST_IDLE;
      end
    end
  end

endmodule
